machine_trap_control: RTL and testbench
=======================================

Name: machine_trap_control

Overview:
- Parametrised successor to the core's machine-mode control FSM.
- Adds full trap entry/return sequencing, prioritised cause encoding, and a configurable boot hold.
- Adds NUM_PLAT_IRQ extra platform interrupt lines on top of the standard external, software and timer interrupts.
- Sits beside the CSR file and PC mux. Drives PC source select, pipeline flush, and the mepc/mcause/mstatus.MIE update strobes.

Parameters:
- NUM_PLAT_IRQ, 4: platform interrupt lines. Line i reports cause 16+i. Legal range 0..16.
- CAUSE_W, 5: width of cause_out. Must be >= 5 when NUM_PLAT_IRQ > 0.
- BOOT_HOLD, 2: cycles spent in RESET after reset release. Must be >= 1.

Ports:
- clk_in  in  1  core clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in  in  1 each  exception flags from decode/LSU.
- opcode_6_to_2_in  in  5  instruction opcode [6:2].
- funct3_in  in  3  instruction funct3.
- funct7_in  in  7  instruction funct7.
- rs1_adder_in, rs2_adder_in, rd_adder_in  in  5 each  register fields.
- mie_in  in  1  mstatus.MIE.
- meie_in, msie_in, mtie_in  in  1 each  mie enable bits.
- meip_in, msip_in, mtip_in  in  1 each  mip pending bits.
- eirq_in, sirq_in, tirq_in  in  1 each  raw interrupt request lines.
- plat_irq_in  in  NUM_PLAT_IRQ  platform interrupt requests.
- plat_irq_en_in  in  NUM_PLAT_IRQ  per-line enables.
- pc_src_out  out  2  PC select: 00 BOOT, 01 NEXT, 10 TRAP, 11 EPC.
- flush_out  out  1  pipeline flush.
- instruct_inc_out  out  1  instret increment enable.
- set_epc_out, set_cause_out  out  1 each  mepc/mcause write strobes.
- mie_clear_out, mie_set_out  out  1 each  mstatus.MIE clear/set strobes.
- trap_taken_out  out  1  high for the TRAP_TAKEN cycle.
- i_or_e_out  out  1  mcause interrupt bit.
- cause_out  out  CAUSE_W  mcause exception code.
- misaligned_exception_out  out  1  registered OR of the three misaligned flags.

Behaviour:
- Decode: system = (opcode_6_to_2_in == 5'b11100), rs1/rd/funct3 all zero.
  - ecall: additionally rs2 = 0, funct7 = 0.
  - ebreak: additionally rs2 = 1, funct7 = 0.
  - mret: additionally rs2 = 2, funct7 = 7'b0011000.
- Pending interrupts:
  - eip = meie & (eirq | meip); sip = msie & (sirq | msip); tip = mtie & (tirq | mtip).
  - pip[i] = plat_irq_en[i] & plat_irq[i].
  - irq = mie_in & (eip | sip | tip | |pip).
- exc = illegal | misaligned_instr | misaligned_load | misaligned_store | ecall | ebreak. trap = irq | exc.
- Priority, highest first, with {i_or_e, cause}:
  - eip {1,11}; sip {1,3}; tip {1,7}; pip lowest index first {1,16+i}.
  - illegal {0,2}; misaligned_instr {0,0}; ecall {0,11}; ebreak {0,3}; misaligned_store {0,6}; misaligned_load {0,4}.
  - Cause codes are zero-extended to CAUSE_W.
- States: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
  - Asynchronous reset forces RESET and clears the hold counter, cause_out, i_or_e_out and misaligned_exception_out.
  - RESET: counts BOOT_HOLD cycles, then goes to OPERATING. Reset asserted mid-operation aborts any state immediately.
  - OPERATING: goes to TRAP_TAKEN if trap; else to TRAP_RETURN if mret; else stays.
  - TRAP_TAKEN and TRAP_RETURN: one cycle each, then OPERATING unconditionally. All trap and mret inputs are ignored in these states.
- Moore outputs (all unlisted outputs 0):
  - RESET: pc_src 00, flush 1.
  - OPERATING: pc_src 01, instruct_inc 1.
  - TRAP_TAKEN: pc_src 10, flush 1, set_epc 1, set_cause 1, mie_clear 1, trap_taken 1.
  - TRAP_RETURN: pc_src 11, flush 1, mie_set 1.
- Cause registers:
  - cause_out and i_or_e_out load the priority-encoder result on the same edge that enters TRAP_TAKEN.
  - They are valid during TRAP_TAKEN and hold until the next trap.
- Simultaneous events:
  - trap and mret in the same cycle: trap wins.
  - Interrupts with mie_in = 0 are masked; exceptions are not.
- misaligned_exception_out: registered every cycle; one-cycle latency.
- Trap entry latency: 1 cycle from the trap condition to TRAP_TAKEN.

Test Plan:
- Reset release with BOOT_HOLD=2 -> pc_src 00 and flush 1 for 2 cycles, then pc_src 01, instruct_inc 1.
- In OPERATING, pulse illegal_instr_in -> next cycle pc_src 10, flush 1, set_epc/set_cause/mie_clear 1, cause_out 2, i_or_e 0; following cycle back to pc_src 01.
- mie_in=1, meie=1, eirq=1 and misaligned_load=1 together -> cause 11, i_or_e 1. Repeat with mie_in=0 -> cause 4, i_or_e 0.
- plat_irq_in=4'b1010, plat_irq_en_in=4'b1111, mie_in=1 -> cause 17, i_or_e 1.
- mret encoding (0x30200073) -> one cycle pc_src 11, flush 1, mie_set 1. mret concurrent with ecall -> TRAP_TAKEN, cause 11.
- Assert rst_n_in low while in TRAP_TAKEN -> outputs immediately take RESET values and cause_out returns to 0, without waiting for a clock edge.

Source files
------------

// File: rtl/machine_trap_control_if.sv
// Bundle between the core datapath and the machine-mode trap controller.
// The core side is the master: it drives decode/CSR/IRQ state and receives the control strobes.
interface machine_trap_control_if #(
  parameter int NUM_PLAT_IRQ = 4,
  parameter int CAUSE_W      = 5
);
  localparam int PW = (NUM_PLAT_IRQ > 0) ? NUM_PLAT_IRQ : 1;

  logic          illegal_instr_in;
  logic          misaligned_instr_in;
  logic          misaligned_load_in;
  logic          misaligned_store_in;
  logic [4:0]    opcode_6_to_2_in;
  logic [2:0]    funct3_in;
  logic [6:0]    funct7_in;
  logic [4:0]    rs1_adder_in;
  logic [4:0]    rs2_adder_in;
  logic [4:0]    rd_adder_in;
  logic          mie_in;
  logic          meie_in;
  logic          msie_in;
  logic          mtie_in;
  logic          meip_in;
  logic          msip_in;
  logic          mtip_in;
  logic          eirq_in;
  logic          sirq_in;
  logic          tirq_in;
  logic [PW-1:0] plat_irq_in;
  logic [PW-1:0] plat_irq_en_in;

  logic [1:0]         pc_src_out;
  logic               flush_out;
  logic               instruct_inc_out;
  logic               set_epc_out;
  logic               set_cause_out;
  logic               mie_clear_out;
  logic               mie_set_out;
  logic               trap_taken_out;
  logic               i_or_e_out;
  logic [CAUSE_W-1:0] cause_out;
  logic               misaligned_exception_out;

  modport master (
    output illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
    output opcode_6_to_2_in, funct3_in, funct7_in, rs1_adder_in, rs2_adder_in, rd_adder_in,
    output mie_in, meie_in, msie_in, mtie_in, meip_in, msip_in, mtip_in,
    output eirq_in, sirq_in, tirq_in, plat_irq_in, plat_irq_en_in,
    input  pc_src_out, flush_out, instruct_inc_out, set_epc_out, set_cause_out,
    input  mie_clear_out, mie_set_out, trap_taken_out, i_or_e_out, cause_out,
    input  misaligned_exception_out
  );

  modport slave (
    input  illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
    input  opcode_6_to_2_in, funct3_in, funct7_in, rs1_adder_in, rs2_adder_in, rd_adder_in,
    input  mie_in, meie_in, msie_in, mtie_in, meip_in, msip_in, mtip_in,
    input  eirq_in, sirq_in, tirq_in, plat_irq_in, plat_irq_en_in,
    output pc_src_out, flush_out, instruct_inc_out, set_epc_out, set_cause_out,
    output mie_clear_out, mie_set_out, trap_taken_out, i_or_e_out, cause_out,
    output misaligned_exception_out
  );
endinterface

// File: rtl/machine_trap_control.sv
// Machine-mode trap controller: boot hold, trap entry/return sequencing and
// prioritised mcause encoding, with all control outputs registered.
module machine_trap_control #(
  parameter int NUM_PLAT_IRQ = 4,
  parameter int CAUSE_W      = 5,
  parameter int BOOT_HOLD    = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  machine_trap_control_if.slave bus
);

  localparam int PW     = (NUM_PLAT_IRQ > 0) ? NUM_PLAT_IRQ : 1;
  localparam int HOLD_W = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    RESET       = 2'd0,
    OPERATING   = 2'd1,
    TRAP_TAKEN  = 2'd2,
    TRAP_RETURN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   holdCnt_q, holdCnt_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;
  logic                iOrE_q, iOrE_d;
  logic                misaligned_q;
  logic [1:0]          pcSrc_q;
  logic                flush_q, instructInc_q, setEpc_q, setCause_q;
  logic                mieClear_q, mieSet_q, trapTaken_q;

  logic          sysBase, isEcall, isEbreak, isMret;
  logic          eip, sip, tip, irq, exc, trap;
  logic [PW-1:0] pip;

  assign sysBase  = (bus.opcode_6_to_2_in == 5'b11100) && (bus.rs1_adder_in == 5'd0) &&
                    (bus.rd_adder_in == 5'd0) && (bus.funct3_in == 3'd0);
  assign isEcall  = sysBase && (bus.rs2_adder_in == 5'd0) && (bus.funct7_in == 7'd0);
  assign isEbreak = sysBase && (bus.rs2_adder_in == 5'd1) && (bus.funct7_in == 7'd0);
  assign isMret   = sysBase && (bus.rs2_adder_in == 5'd2) && (bus.funct7_in == 7'b0011000);

  assign eip = bus.meie_in & (bus.eirq_in | bus.meip_in);
  assign sip = bus.msie_in & (bus.sirq_in | bus.msip_in);
  assign tip = bus.mtie_in & (bus.tirq_in | bus.mtip_in);
  assign pip = (NUM_PLAT_IRQ > 0) ? (bus.plat_irq_in & bus.plat_irq_en_in) : '0;
  assign irq = bus.mie_in & (eip | sip | tip | (|pip));
  assign exc = bus.illegal_instr_in | bus.misaligned_instr_in | bus.misaligned_load_in |
               bus.misaligned_store_in | isEcall | isEbreak;
  assign trap = irq | exc;

  // Interrupts outrank exceptions; platform lines scanned downward so the lowest index wins.
  always_comb begin
    cause_d = '0;
    iOrE_d  = 1'b0;
    if (irq) begin
      iOrE_d = 1'b1;
      if (eip)      cause_d = CAUSE_W'(11);
      else if (sip) cause_d = CAUSE_W'(3);
      else if (tip) cause_d = CAUSE_W'(7);
      else begin
        for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
          if (pip[i]) cause_d = CAUSE_W'(16 + i);
        end
      end
    end else if (bus.illegal_instr_in)    cause_d = CAUSE_W'(2);
    else if (bus.misaligned_instr_in)     cause_d = CAUSE_W'(0);
    else if (isEcall)                     cause_d = CAUSE_W'(11);
    else if (isEbreak)                    cause_d = CAUSE_W'(3);
    else if (bus.misaligned_store_in)     cause_d = CAUSE_W'(6);
    else if (bus.misaligned_load_in)      cause_d = CAUSE_W'(4);
  end

  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    case (state_q)
      RESET: begin
        if (holdCnt_q == HOLD_W'(BOOT_HOLD - 1)) state_d = OPERATING;
        else holdCnt_d = holdCnt_q + HOLD_W'(1);
      end
      OPERATING: begin
        if (trap)        state_d = TRAP_TAKEN;
        else if (isMret) state_d = TRAP_RETURN;
      end
      TRAP_TAKEN:  state_d = OPERATING;
      TRAP_RETURN: state_d = OPERATING;
      default:     state_d = RESET;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= RESET;
      holdCnt_q     <= '0;
      cause_q       <= '0;
      iOrE_q        <= 1'b0;
      misaligned_q  <= 1'b0;
      pcSrc_q       <= 2'b00;
      flush_q       <= 1'b1;
      instructInc_q <= 1'b0;
      setEpc_q      <= 1'b0;
      setCause_q    <= 1'b0;
      mieClear_q    <= 1'b0;
      mieSet_q      <= 1'b0;
      trapTaken_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      holdCnt_q    <= holdCnt_d;
      misaligned_q <= bus.misaligned_instr_in | bus.misaligned_load_in | bus.misaligned_store_in;
      if (state_d == TRAP_TAKEN) begin
        cause_q <= cause_d;
        iOrE_q  <= iOrE_d;
      end
      pcSrc_q       <= 2'(state_d);
      flush_q       <= (state_d != OPERATING);
      instructInc_q <= (state_d == OPERATING);
      setEpc_q      <= (state_d == TRAP_TAKEN);
      setCause_q    <= (state_d == TRAP_TAKEN);
      mieClear_q    <= (state_d == TRAP_TAKEN);
      trapTaken_q   <= (state_d == TRAP_TAKEN);
      mieSet_q      <= (state_d == TRAP_RETURN);
    end
  end

  assign bus.pc_src_out               = pcSrc_q;
  assign bus.flush_out                = flush_q;
  assign bus.instruct_inc_out         = instructInc_q;
  assign bus.set_epc_out              = setEpc_q;
  assign bus.set_cause_out            = setCause_q;
  assign bus.mie_clear_out            = mieClear_q;
  assign bus.mie_set_out              = mieSet_q;
  assign bus.trap_taken_out           = trapTaken_q;
  assign bus.i_or_e_out               = iOrE_q;
  assign bus.cause_out                = cause_q;
  assign bus.misaligned_exception_out = misaligned_q;

endmodule

// File: tb/tb_machine_trap_control.sv
// Directed bench for machine_trap_control: expected outputs are queued per cycle
// by the stimulus thread and compared by an independent negedge monitor.
module tb_machine_trap_control;

  localparam int NPI = 4;
  localparam int CW  = 5;

  typedef struct packed {
    logic [1:0]    pcSrc;
    logic          flush;
    logic          inc;
    logic          setEpc;
    logic          setCause;
    logic          mieClr;
    logic          mieSet;
    logic          trapTaken;
    logic          iOrE;
    logic [CW-1:0] cause;
    logic          misal;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t o;
  } entry_t;

  logic   clk = 1'b0;
  logic   rstN = 1'b1;
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;
  entry_t expQ[$];
  logic [CW-1:0] lastCause = '0;
  logic          lastIorE = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  machine_trap_control_if #(.NUM_PLAT_IRQ(NPI), .CAUSE_W(CW)) bus ();

  machine_trap_control #(.NUM_PLAT_IRQ(NPI), .CAUSE_W(CW), .BOOT_HOLD(2)) dut (
    .clk_in   (clk),
    .rst_n_in (rstN),
    .bus      (bus)
  );

  function automatic outs_t expState(input int st, input logic misal);
    outs_t e;
    e = '0;
    e.iOrE  = lastIorE;
    e.cause = lastCause;
    e.misal = misal;
    case (st)
      0: begin e.pcSrc = 2'b00; e.flush = 1'b1; end
      1: begin e.pcSrc = 2'b01; e.inc = 1'b1; end
      2: begin
        e.pcSrc = 2'b10; e.flush = 1'b1; e.setEpc = 1'b1; e.setCause = 1'b1;
        e.mieClr = 1'b1; e.trapTaken = 1'b1;
      end
      default: begin e.pcSrc = 2'b11; e.flush = 1'b1; e.mieSet = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic outs_t sampleDut();
    outs_t a;
    a.pcSrc     = bus.pc_src_out;
    a.flush     = bus.flush_out;
    a.inc       = bus.instruct_inc_out;
    a.setEpc    = bus.set_epc_out;
    a.setCause  = bus.set_cause_out;
    a.mieClr    = bus.mie_clear_out;
    a.mieSet    = bus.mie_set_out;
    a.trapTaken = bus.trap_taken_out;
    a.iOrE      = bus.i_or_e_out;
    a.cause     = bus.cause_out;
    a.misal     = bus.misaligned_exception_out;
    return a;
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("pc=%b fl=%b inc=%b epc=%b cs=%b mclr=%b mset=%b tt=%b ie=%b cause=%0d mis=%b",
                     o.pcSrc, o.flush, o.inc, o.setEpc, o.setCause, o.mieClr, o.mieSet,
                     o.trapTaken, o.iOrE, o.cause, o.misal);
  endfunction

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = sampleDut();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got {%s} required {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  // Monitor: compares whatever the DUT presents against the entry queued for this cycle.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      entry_t e;
      e = expQ.pop_front();
      checkOutput($sformatf("cycle %0d", e.cyc), e.o);
    end
  end

  task automatic clearInputs();
    bus.illegal_instr_in    = 1'b0;
    bus.misaligned_instr_in = 1'b0;
    bus.misaligned_load_in  = 1'b0;
    bus.misaligned_store_in = 1'b0;
    bus.opcode_6_to_2_in    = 5'd0;
    bus.funct3_in           = 3'd0;
    bus.funct7_in           = 7'd0;
    bus.rs1_adder_in        = 5'd0;
    bus.rs2_adder_in        = 5'd0;
    bus.rd_adder_in         = 5'd0;
    bus.mie_in              = 1'b0;
    bus.meie_in             = 1'b0;
    bus.msie_in             = 1'b0;
    bus.mtie_in             = 1'b0;
    bus.meip_in             = 1'b0;
    bus.msip_in             = 1'b0;
    bus.mtip_in             = 1'b0;
    bus.eirq_in             = 1'b0;
    bus.sirq_in             = 1'b0;
    bus.tirq_in             = 1'b0;
    bus.plat_irq_in         = '0;
    bus.plat_irq_en_in      = '0;
  endtask

  task automatic setInstr(input logic [31:0] ins);
    bus.opcode_6_to_2_in = ins[6:2];
    bus.rd_adder_in      = ins[11:7];
    bus.funct3_in        = ins[14:12];
    bus.rs1_adder_in     = ins[19:15];
    bus.rs2_adder_in     = ins[24:20];
    bus.funct7_in        = ins[31:25];
  endtask

  // Inputs are already set; queue the response expected after the next edge, then step.
  task automatic applyStimulus(input outs_t exp);
    entry_t e;
    e.cyc = cyc + 1;
    e.o   = exp;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic expectTrap(input int cause, input logic iore, input logic misal);
    lastCause = CW'(cause);
    lastIorE  = iore;
    applyStimulus(expState(2, misal));
  endtask

  task automatic idleOp();
    clearInputs();
    applyStimulus(expState(1, 1'b0));
  endtask

  initial begin
    clearInputs();
    #1 rstN = 1'b0;
    #1 checkOutput("async reset at start", expState(0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(expState(0, 1'b0));
    applyStimulus(expState(1, 1'b0));
    idleOp();

    bus.illegal_instr_in = 1'b1;
    expectTrap(2, 1'b0, 1'b0);
    bus.illegal_instr_in = 1'b0;
    applyStimulus(expState(1, 1'b0));

    bus.mie_in = 1'b1; bus.meie_in = 1'b1; bus.eirq_in = 1'b1; bus.misaligned_load_in = 1'b1;
    expectTrap(11, 1'b1, 1'b1);
    idleOp();

    bus.mie_in = 1'b0; bus.meie_in = 1'b1; bus.eirq_in = 1'b1; bus.misaligned_load_in = 1'b1;
    expectTrap(4, 1'b0, 1'b1);
    idleOp();

    bus.mie_in = 1'b1; bus.plat_irq_in = 4'b1010; bus.plat_irq_en_in = 4'b1111;
    expectTrap(17, 1'b1, 1'b0);
    idleOp();

    bus.mie_in = 1'b1; bus.plat_irq_in = 4'b0101; bus.plat_irq_en_in = 4'b0100;
    expectTrap(18, 1'b1, 1'b0);
    idleOp();

    bus.mie_in = 1'b1; bus.msie_in = 1'b1; bus.msip_in = 1'b1;
    bus.mtie_in = 1'b1; bus.mtip_in = 1'b1; bus.misaligned_store_in = 1'b1;
    expectTrap(3, 1'b1, 1'b1);
    idleOp();

    bus.mie_in = 1'b1; bus.mtie_in = 1'b1; bus.tirq_in = 1'b1; bus.illegal_instr_in = 1'b1;
    expectTrap(7, 1'b1, 1'b0);
    idleOp();

    bus.mie_in = 1'b0; bus.meie_in = 1'b1; bus.eirq_in = 1'b1;
    applyStimulus(expState(1, 1'b0));
    bus.mie_in = 1'b1; bus.meie_in = 1'b0;
    applyStimulus(expState(1, 1'b0));
    clearInputs();

    setInstr(32'h0000_0073);
    expectTrap(11, 1'b0, 1'b0);
    idleOp();
    setInstr(32'h0010_0073);
    expectTrap(3, 1'b0, 1'b0);
    idleOp();
    bus.misaligned_instr_in = 1'b1; bus.misaligned_store_in = 1'b1;
    expectTrap(0, 1'b0, 1'b1);
    idleOp();
    bus.misaligned_store_in = 1'b1;
    expectTrap(6, 1'b0, 1'b1);
    idleOp();

    setInstr(32'h3020_0073);
    applyStimulus(expState(3, 1'b0));
    idleOp();

    bus.illegal_instr_in = 1'b1;
    expectTrap(2, 1'b0, 1'b0);
    setInstr(32'h3020_0073);
    applyStimulus(expState(1, 1'b0));
    idleOp();

    setInstr(32'h3020_0073);
    bus.mie_in = 1'b1; bus.meie_in = 1'b1; bus.eirq_in = 1'b1;
    expectTrap(11, 1'b1, 1'b0);
    idleOp();

    bus.illegal_instr_in = 1'b1;
    expectTrap(2, 1'b0, 1'b0);
    clearInputs();
    @(negedge clk);
    #1;
    rstN = 1'b0;
    lastCause = '0;
    lastIorE  = 1'b0;
    #1 checkOutput("async reset in TRAP_TAKEN", expState(0, 1'b0));
    @(posedge clk);
    #1;
    rstN = 1'b1;
    applyStimulus(expState(0, 1'b0));
    applyStimulus(expState(1, 1'b0));
    idleOp();

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d queued entries required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
